// File: rtl/uart_instr_loader.sv
// uart_instr_loader
// Receives instruction-memory images over a byte stream (typically a UART
// receiver) and writes them into instruction memory one word at a time.
// Frame: 0xA5, LEN_HI, LEN_LO, LEN words (high byte first), CHK.
// CHK is the 8-bit XOR of every byte between SYNC and CHK.
// done/error are sticky status flags for the last frame and are cleared by
// the next SYNC byte (or reset).

module uart_instr_loader #(
  parameter int INSTRUCTION_WIDTH    = 16,
  parameter int INSTRUCTION_MEM_SIZE = 1024,
  parameter int TIMEOUT_CYCLES       = 2_517_500
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [7:0]                              data_in,
  input  logic                                    data_in_valid,
  output logic                                    instr_mem_write_enable,
  output logic [$clog2(INSTRUCTION_MEM_SIZE)-1:0] instr_mem_write_addr,
  output logic [INSTRUCTION_WIDTH-1:0]            instr_mem_write_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error
);

  localparam int ADDR_W = $clog2(INSTRUCTION_MEM_SIZE);
  // Counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK
  } state_t;

  // Registered state
  state_t                         r_state;
  logic [7:0]                     r_len_hi;
  logic [15:0]                    r_len;
  logic [7:0]                     r_data_hi;
  logic [7:0]                     r_chk;
  logic [ADDR_W-1:0]              r_idx;
  logic [TO_W-1:0]                r_to_cnt;
  logic                           r_done;
  logic                           r_error;
  logic                           r_we;
  logic [ADDR_W-1:0]              r_addr;
  logic [INSTRUCTION_WIDTH-1:0]   r_data;

  // Next-state values
  state_t                         w_state_next;
  logic [7:0]                     w_len_hi_next;
  logic [15:0]                    w_len_next;
  logic [7:0]                     w_data_hi_next;
  logic [7:0]                     w_chk_next;
  logic [ADDR_W-1:0]              w_idx_next;
  logic [TO_W-1:0]                w_to_cnt_next;
  logic                           w_done_next;
  logic                           w_error_next;
  logic                           w_we_next;
  logic [ADDR_W-1:0]              w_addr_next;
  logic [INSTRUCTION_WIDTH-1:0]   w_data_next;

  // Decoded helpers
  logic [15:0]                    w_len_rx;
  logic                           w_len_bad;
  logic                           w_last_word;
  logic                           w_timeout;
  logic [7:0]                     w_chk_upd;

  // Length as it will be once the LEN_LO byte currently on data_in is taken.
  assign w_len_rx    = {r_len_hi, data_in};
  assign w_len_bad   = (w_len_rx == 16'd0) ||
                       (32'(w_len_rx) > 32'(INSTRUCTION_MEM_SIZE));
  // Word index of the final word is LEN-1; LEN is never 0 in the data states.
  assign w_last_word = (16'(r_idx) == (r_len - 16'd1));
  // Gap limit reached on a cycle with no byte: abort the frame now.
  assign w_timeout   = (r_state != S_IDLE) && !data_in_valid &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_chk_upd   = r_chk ^ data_in;

  assign busy                   = (r_state != S_IDLE);
  assign done                   = r_done;
  assign error                  = r_error;
  assign instr_mem_write_enable = r_we;
  assign instr_mem_write_addr   = r_addr;
  assign instr_mem_write_data   = r_data;

  // Next-state and datapath decode: one byte at most is consumed per cycle.
  always_comb begin
    w_state_next   = r_state;
    w_len_hi_next  = r_len_hi;
    w_len_next     = r_len;
    w_data_hi_next = r_data_hi;
    w_chk_next     = r_chk;
    w_idx_next     = r_idx;
    w_to_cnt_next  = r_to_cnt;
    w_done_next    = r_done;
    w_error_next   = r_error;
    w_we_next      = 1'b0;
    w_addr_next    = r_addr;
    w_data_next    = r_data;

    // Inter-byte gap counter runs only inside a frame and restarts on each byte.
    if (r_state != S_IDLE) begin
      w_to_cnt_next = data_in_valid ? '0 : TO_W'(r_to_cnt + 1'b1);
    end

    if (w_timeout) begin
      w_state_next  = S_IDLE;
      w_error_next  = 1'b1;
      w_done_next   = 1'b0;
      w_to_cnt_next = '0;
    end else if (data_in_valid) begin
      case (r_state)
        S_IDLE: begin
          // Anything but SYNC is line noise while idle.
          if (data_in == SYNC_BYTE) begin
            w_state_next  = S_LEN_HI;
            w_done_next   = 1'b0;
            w_error_next  = 1'b0;
            w_chk_next    = 8'h00;
            w_idx_next    = '0;
            w_to_cnt_next = '0;
          end
        end
        S_LEN_HI: begin
          w_len_hi_next = data_in;
          w_chk_next    = w_chk_upd;
          w_state_next  = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_len_next = w_len_rx;
          w_chk_next = w_chk_upd;
          if (w_len_bad) begin
            w_state_next = S_IDLE;
            w_error_next = 1'b1;
          end else begin
            w_state_next = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          // A 0xA5 here is payload; there is no mid-frame resync.
          w_data_hi_next = data_in;
          w_chk_next     = w_chk_upd;
          w_state_next   = S_DATA_LO;
        end
        S_DATA_LO: begin
          w_chk_next   = w_chk_upd;
          w_we_next    = 1'b1;
          w_addr_next  = r_idx;
          w_data_next  = INSTRUCTION_WIDTH'({r_data_hi, data_in});
          w_idx_next   = ADDR_W'(r_idx + 1'b1);
          w_state_next = w_last_word ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          if (data_in == r_chk) begin
            w_done_next = 1'b1;
          end else begin
            w_error_next = 1'b1;
          end
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len_hi  <= 8'h00;
      r_len     <= 16'h0000;
      r_data_hi <= 8'h00;
      r_chk     <= 8'h00;
      r_idx     <= '0;
      r_to_cnt  <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_len_hi  <= w_len_hi_next;
      r_len     <= w_len_next;
      r_data_hi <= w_data_hi_next;
      r_chk     <= w_chk_next;
      r_idx     <= w_idx_next;
      r_to_cnt  <= w_to_cnt_next;
      r_done    <= w_done_next;
      r_error   <= w_error_next;
      r_we      <= w_we_next;
      r_addr    <= w_addr_next;
      r_data    <= w_data_next;
    end
  end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Testbench for uart_instr_loader: directed frames followed by randomized
// frames, checked against a frame-level model of the loader protocol.

module tb_uart_instr_loader;

  localparam int MEM  = 16;
  localparam int TO   = 200;
  localparam int AW   = $clog2(MEM);

  logic          clk;
  logic          rst;
  logic [7:0]    data_in;
  logic          data_in_valid;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          busy;
  logic          done;
  logic          error;

  uart_instr_loader #(
    .INSTRUCTION_WIDTH   (16),
    .INSTRUCTION_MEM_SIZE(MEM),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_in               (data_in),
    .data_in_valid         (data_in_valid),
    .instr_mem_write_enable(we),
    .instr_mem_write_addr  (waddr),
    .instr_mem_write_data  (wdata),
    .busy                  (busy),
    .done                  (done),
    .error                 (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_mis = 0;

  // Expected observable state
  logic          exp_busy;
  logic          exp_done;
  logic          exp_err;
  logic [AW-1:0] exp_addr;
  logic [15:0]   exp_data;

  logic [15:0]   words [0:MEM-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_we);
    check({tag, ".we"},    32'(we),    32'(exp_we));
    check({tag, ".busy"},  32'(busy),  32'(exp_busy));
    check({tag, ".done"},  32'(done),  32'(exp_done));
    check({tag, ".error"}, 32'(error), 32'(exp_err));
    check({tag, ".addr"},  32'(waddr), 32'(exp_addr));
    check({tag, ".data"},  32'(wdata), 32'(exp_data));
  endtask

  // One byte presented for exactly one cycle; outputs sampled 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    data_in       = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in       = 8'($urandom);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_out(tag, 1'b0);
    end
  endtask

  task automatic gap(input int gapmax);
    idle(int'($urandom_range(gapmax, 0)), "gap");
  endtask

  // Frame-level model: words[] holds the payload, len the declared length.
  task automatic run_frame(input int len, input int gapmax, input bit bad_chk);
    logic [15:0] len16;
    logic [7:0]  chk;
    logic [7:0]  b;
    len16 = 16'(len);
    chk   = len16[15:8] ^ len16[7:0];
    send(8'hA5);
    exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    check_out("sync", 1'b0);
    gap(gapmax);
    send(len16[15:8]);
    check_out("len_hi", 1'b0);
    gap(gapmax);
    send(len16[7:0]);
    if (len == 0 || len > MEM) begin
      exp_busy = 1'b0; exp_err = 1'b1;
      check_out("len_bad", 1'b0);
      $display("frame len=%0d rejected: error=%0b busy=%0b", len, error, busy);
      return;
    end
    check_out("len_lo", 1'b0);
    for (int k = 0; k < len; k++) begin
      gap(gapmax);
      b = words[k][15:8];
      send(b);
      check_out("data_hi", 1'b0);
      gap(gapmax);
      b = words[k][7:0];
      send(b);
      exp_addr = AW'(k);
      exp_data = words[k];
      check_out("write", 1'b1);
      chk = chk ^ words[k][15:8] ^ words[k][7:0];
    end
    gap(gapmax);
    if (bad_chk) b = (chk == 8'h00) ? 8'hFF : 8'h00;
    else         b = chk;
    send(b);
    exp_busy = 1'b0; exp_done = !bad_chk; exp_err = bad_chk;
    check_out("chk", 1'b0);
    $display("frame len=%0d chk=%02h sent=%02h: done=%0b error=%0b", len, chk, b, done, error);
  endtask

  initial begin
    int len;
    int mode;
    logic [7:0] g;

    rst = 1'b1; data_in = 8'h00; data_in_valid = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 1'b0);
    rst = 1'b0;
    idle(2, "post_reset");

    // Noise before a frame is ignored, then a 1-word frame loads.
    send(8'h55); check_out("noise55", 1'b0);
    send(8'hFF); check_out("noiseFF", 1'b0);
    words[0] = 16'h0F0E;
    run_frame(1, 0, 1'b0);

    // Two-word reference frame, back-to-back bytes, good then bad checksum.
    words[0] = 16'h1234; words[1] = 16'hABCD;
    run_frame(2, 0, 1'b0);
    run_frame(2, 0, 1'b1);

    // Length limits.
    run_frame(0, 0, 1'b0);
    run_frame(16'h0401, 0, 1'b0);
    run_frame(MEM + 1, 1, 1'b0);
    for (int k = 0; k < MEM; k++) words[k] = 16'(k * 16'h1111 + 16'hA5A5);
    run_frame(MEM, 0, 1'b0);

    // Inter-byte timeout fires exactly TO cycles after the last byte.
    send(8'hA5); exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0; check_out("to_sync", 1'b0);
    send(8'h00); check_out("to_lhi", 1'b0);
    send(8'h01); check_out("to_llo", 1'b0);
    send(8'h12); check_out("to_hi", 1'b0);
    idle(TO - 1, "to_wait");
    exp_busy = 1'b0; exp_err = 1'b1;
    idle(1, "to_fire");
    $display("timeout: error=%0b busy=%0b", error, busy);
    idle(3, "to_after");
    words[0] = 16'hC3C3;
    run_frame(1, 2, 1'b0);

    // Reset in the middle of a frame.
    send(8'hA5); exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0; check_out("rm_sync", 1'b0);
    send(8'h00); check_out("rm_lhi", 1'b0);
    send(8'h01); check_out("rm_llo", 1'b0);
    send(8'h12); check_out("rm_hi", 1'b0);
    rst = 1'b1;
    #1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
    check_out("rst_mid", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h34); check_out("post_rst_byte", 1'b0);
    idle(2, "post_rst_idle");
    $display("mid-frame reset: we=%0b busy=%0b addr=%0h data=%0h", we, busy, waddr, wdata);
    words[0] = 16'h1234;
    run_frame(1, 0, 1'b0);

    // Randomized frames with noise, gaps, payload 0xA5 bytes and bad lengths/checksums.
    for (int f = 0; f < 14; f++) begin
      for (int n = int'($urandom_range(3, 0)); n > 0; n--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send(g);
        check_out("rand_noise", 1'b0);
      end
      mode = int'($urandom_range(7, 0));
      if (mode == 0)      len = 0;
      else if (mode == 1) len = MEM + 1 + int'($urandom_range(500, 0));
      else                len = int'($urandom_range(MEM, 1));
      for (int k = 0; k < MEM; k++) begin
        words[k] = 16'($urandom);
        if ($urandom_range(3, 0) == 0) words[k][15:8] = 8'hA5;
        if ($urandom_range(3, 0) == 0) words[k][7:0]  = 8'hA5;
      end
      run_frame(len, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      idle(int'($urandom_range(2, 0)), "rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
